// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Holds the FSM state encoding and the iteration-counter width rule.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 8;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/CLA_4bit_slice.sv
// 4-bit adder slice with full carry lookahead; the building block for the
// wider adders and subtractors in the arithmetic library.
module CLA_4bit_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
        o_sum  = w_p ^ w_c[3:0];
        o_cout = w_c[4];
    end

endmodule

// File: rtl/div_trial_sub.sv
// (WIDTH+1)-bit trial subtractor for the divider: minuend - subtrahend as
// minuend + ~subtrahend + 1 over a chain of 4-bit lookahead slices.
module div_trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_minuend,
    input  logic [WIDTH:0] i_subtrahend,
    output logic [WIDTH:0] o_diff,
    output logic           o_borrow
);

    localparam int N_LO = WIDTH / 4;

    logic [WIDTH:0]   w_sub_inv;
    logic [WIDTH-1:0] w_sum_lo;
    logic [N_LO:0]    w_carry;
    logic [3:0]       w_sum_top;
    logic             w_cout_top;
    logic [2:0]       w_pad_unused;

    assign w_sub_inv  = ~i_subtrahend;
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < N_LO; gi++) begin : g_slice
        CLA_4bit_slice u_slice (
            .i_a    (i_minuend[4*gi +: 4]),
            .i_b    (w_sub_inv[4*gi +: 4]),
            .i_cin  (w_carry[gi]),
            .o_sum  (w_sum_lo[4*gi +: 4]),
            .o_cout (w_carry[gi+1])
        );
    end

    // Top slice carries bit WIDTH plus zero padding; the padded subtrahend
    // bits invert to ones, so the slice carry-out equals the carry out of bit WIDTH.
    CLA_4bit_slice u_slice_top (
        .i_a    ({3'b000, i_minuend[WIDTH]}),
        .i_b    ({3'b111, w_sub_inv[WIDTH]}),
        .i_cin  (w_carry[N_LO]),
        .o_sum  (w_sum_top),
        .o_cout (w_cout_top)
    );

    assign o_diff       = {w_sum_top[0], w_sum_lo};
    assign o_borrow     = ~w_cout_top;
    assign w_pad_unused = w_sum_top[3:1];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, results held until the next accepted operation.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivByZero
);

    localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : cnt_width(WIDTH);

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH:0]   w_r_next;
    logic             w_r_msb_unused;

    // R never exceeds D after a restore, so its top bit only guards the subtract.
    assign w_r_msb_unused = r_r[WIDTH];

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .i_minuend    (w_rs),
        .i_subtrahend ({1'b0, r_d}),
        .o_diff       (w_diff),
        .o_borrow     (w_borrow)
    );

    // One restoring iteration: shift in the next dividend bit, keep T on no borrow.
    always_comb begin
        w_rs     = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
        w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
        if (w_borrow) begin
            w_r_next = w_rs;
        end else begin
            w_r_next = w_diff;
        end
    end

    // Control FSM, iteration datapath registers and registered result outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (iStart && (iDivisor != '0)) begin
                        r_q     <= iDividend;
                        r_r     <= '0;
                        r_d     <= iDivisor;
                        r_cnt   <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else if (iStart) begin
                        r_quot  <= '1;
                        r_rem   <= iDividend;
                        r_dbz   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_r_next[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign oQuotient  = r_quot;
    assign oRemainder = r_rem;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oDivByZero = r_dbz;

endmodule
